// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// UART_ARB_ID_HDR_EN adds the HDR state used to send a requester-ID header byte.
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam logic [3:0] UART_HDR_TAG = 4'hA;

`ifdef UART_ARB_ID_HDR_EN
    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        HDR
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_e;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after last_grant, with wrap-around.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant,
    output logic         any_req
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the scan so no latch is inferred.
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= N) idx = idx - N;
            if (!any_req && req[idx]) begin
                grant   = W'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one single-byte UART transmit engine.
// Define UART_ARB_ID_HDR_EN to prefix every packet with header byte 8'hA0 | grant_id.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [REQ_W-1:0]          grant_id,
    output logic                      grant_active
);

    arb_state_e       state;
    logic [REQ_W-1:0] last_grant;
    logic [REQ_W-1:0] pick;
    logic             any_req;
    logic             last_q;

    rr_arbiter #(
        .N (NUM_REQ),
        .W (REQ_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick),
        .any_req    (any_req)
    );

    always_comb begin
        req_ready = '0;
        if (state == SEND) req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            last_q       <= 1'b0;
            last_grant   <= REQ_W'(NUM_REQ - 1);
        end else begin
            // NOTE: non-blocking default makes tx_start a one-cycle pulse unless a load re-arms it.
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id     <= pick;
                        grant_active <= 1'b1;
`ifdef UART_ARB_ID_HDR_EN
                        state        <= HDR;
`else
                        state        <= SEND;
`endif
                    end
                end
`ifdef UART_ARB_ID_HDR_EN
                HDR: begin
                    tx_data  <= {UART_HDR_TAG, 4'h0} | BYTE_W'(grant_id);
                    last_q   <= 1'b0;
                    tx_start <= 1'b1;
                    state    <= WAIT_BUSY;
                end
`endif
                SEND: begin
                    if (req_valid[grant_id]) begin
                        tx_data  <= req_data[int'(grant_id)*BYTE_W +: BYTE_W];
                        last_q   <= req_last[grant_id];
                        tx_start <= 1'b1;
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // The engine's busy is registered, so only its falling edge marks the byte done.
                    if (!tx_busy) begin
                        if (last_q) begin
                            last_grant   <= grant_id;
                            grant_active <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a modelled UART engine and a byte scoreboard.
// Expects the header byte when UART_ARB_ID_HDR_EN is defined.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int FRAME   = 6;
    localparam int BUDGET  = 3000;
`ifdef UART_ARB_ID_HDR_EN
    localparam int HDR_N = 1;
`else
    localparam int HDR_N = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   req_valid, req_last, req_ready;
    logic [31:0]  req_data;
    logic         tx_start, tx_busy, grant_active;
    logic [7:0]   tx_data;
    logic [1:0]   grant_id;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .grant_active (grant_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        int         exp;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    exp_t       sb[$];
    logic [8:0] src_mem[NUM_REQ][64];
    int         src_head[NUM_REQ];
    int         src_tail[NUM_REQ];
    int         ready_cnt[NUM_REQ];
    logic [3:0] en_mask = '1;
    logic [3:0] stall = '0;
    logic [3:0] acc = '0;
    int         acc_total = 0;
    int         last_acc_id = -1;
    int         start_cnt = 0;
    int         eng_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_src(input int id, input logic [7:0] d, input logic l);
        src_mem[id][src_tail[id]] = {l, d};
        src_tail[id]++;
    endtask

    task automatic exp_byte(input int id, input logic [7:0] d);
        sb.push_back('{id: 4'(id), data: d});
    endtask

    task automatic exp_hdr(input int id);
`ifdef UART_ARB_ID_HDR_EN
        exp_byte(id, 8'hA0 | 8'(id));
`else
        if (id < 0) exp_byte(id, 8'h00);
`endif
    endtask

    // Queue a packet at a requester and its expected bytes (header first) on the scoreboard.
    task automatic send_pkt(input int id, input int n, input logic [7:0] base);
        exp_hdr(id);
        for (int k = 0; k < n; k++) begin
            push_src(id, base + 8'(k), k == n - 1);
            exp_byte(id, base + 8'(k));
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || grant_active || tx_busy || eng_cnt != 0) && n < BUDGET) begin
            @(negedge clk); #2;
            n++;
        end
        check(name, 32'(n < BUDGET), 1);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        sb.delete();
        acc = '0;
        en_mask = '1;
        stall = '0;
        for (int i = 0; i < NUM_REQ; i++) src_head[i] = src_tail[i];
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_grant_active"}, 32'(grant_active), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
    endtask

    // Requester sources: present queued bytes, pop on the handshake seen before the last edge.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) if (acc[i]) src_head[i]++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_head[i] != src_tail[i] && en_mask[i] && !stall[i]) begin
                    req_valid[i] = 1'b1;
                    {req_last[i], req_data[8*i +: 8]} = src_mem[i][src_head[i]];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i] = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                end
            end
            #1;
            acc = req_valid & req_ready;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) begin
                    ready_cnt[i]++;
                    acc_total++;
                    last_acc_id = i;
                end
            end
        end
    end

    // Engine model: busy rises two cycles after start, lasts FRAME cycles; each start is scored.
    initial begin
        tx_busy = 1'b0;
        forever begin
            exp_t e;
            @(negedge clk);
            if (!rst_n) begin
                eng_cnt = 0;
                tx_busy = 1'b0;
            end else begin
                if (eng_cnt > 0) eng_cnt--;
                tx_busy = (eng_cnt > 0 && eng_cnt <= FRAME);
                if (tx_start) begin
                    start_cnt++;
                    check("engine_idle_at_start", eng_cnt, 0);
                    check("start_expected", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("tx_data", 32'(tx_data), 32'(e.data));
                        check("grant_at_start", 32'(grant_id), 32'(e.id));
                    end
                    eng_cnt = FRAME + 2;
                end
            end
        end
    end

    initial begin
        vec_t tbl[10];
        int   n, s0, r0, a0, e;

        tbl[0] = '{4'b1111, 0};
        tbl[1] = '{4'b1111, 1};
        tbl[2] = '{4'b1111, 2};
        tbl[3] = '{4'b1111, 3};
        tbl[4] = '{4'b1111, 0};
        tbl[5] = '{4'b0100, 2};
        tbl[6] = '{4'b1001, 3};
        tbl[7] = '{4'b1001, 0};
        tbl[8] = '{4'b0010, 1};
        tbl[9] = '{4'b1100, 2};

        // Reset values while rst_n is held low.
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Single-byte packet from requester 2.
        r0 = ready_cnt[2];
        s0 = start_cnt;
        send_pkt(2, 1, 8'h55);
        n = 0;
        while (!grant_active && n < 50) begin @(negedge clk); #2; n++; end
        check("a_grant_active_rise", 32'(grant_active), 1);
        check("a_grant_id", 32'(grant_id), 2);
        wait_idle("a_idle");
        check("a_ready_pulses", ready_cnt[2] - r0, 1);
        check("a_starts", start_cnt - s0, 1 + HDR_N);
        check("a_grant_active_fall", 32'(grant_active), 0);

        // Simultaneous 3-byte packets from 0 and 1: no interleaving.
        do_reset();
        s0 = start_cnt;
        send_pkt(0, 3, 8'h01);
        send_pkt(1, 3, 8'h11);
        wait_idle("b_idle");
        check("b_starts", start_cnt - s0, 6 + 2 * HDR_N);

        // Owner stalls 10 cycles mid-packet while requester 3 waits.
        do_reset();
        r0 = ready_cnt[0];
        send_pkt(0, 3, 8'h21);
        send_pkt(3, 1, 8'h44);
        n = 0;
        while (ready_cnt[0] == r0 && n < 200) begin @(negedge clk); #2; n++; end
        check("c_first_accept", 32'(n < 200), 1);
        stall[0] = 1'b1;
        repeat (FRAME + 6) @(negedge clk);
        s0 = start_cnt;
        repeat (10) @(negedge clk);
        check("c_no_start_in_stall", start_cnt - s0, 0);
        check("c_grant_held", 32'(grant_id), 0);
        check("c_active_held", 32'(grant_active), 1);
        #2 stall[0] = 1'b0;
        wait_idle("c_idle");
        check("c_ready_pulses", ready_cnt[0] - r0, 3);
        check("c_last_owner", last_acc_id, 3);

        // Reset while in WAIT_DONE, then priority restarts at requester 0.
        do_reset();
        send_pkt(0, 1, 8'h5A);
        wait_idle("d_pre_idle");
        send_pkt(1, 1, 8'h77);
        n = 0;
        while (!tx_busy && n < 100) begin @(negedge clk); #2; n++; end
        check("d_busy_seen", 32'(tx_busy), 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1 check_reset_outputs("d_rst");
        sb.delete();
        acc = '0;
        for (int i = 0; i < NUM_REQ; i++) src_head[i] = src_tail[i];
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        send_pkt(0, 1, 8'h30);
        send_pkt(3, 1, 8'h33);
        wait_idle("d_post_idle");

        // Requester 1 single byte: one ready pulse, header first when enabled.
        do_reset();
        r0 = ready_cnt[1];
        s0 = start_cnt;
        send_pkt(1, 1, 8'h3C);
        wait_idle("e_idle");
        check("e_ready_pulses", ready_cnt[1] - r0, 1);
        check("e_starts", start_cnt - s0, 1 + HDR_N);

        // Round-robin vectors: each row enables a request mask and expects one winner.
        do_reset();
        for (int r = 0; r < 10; r++) begin
            en_mask = '0;
            wait_idle("tbl_pre_idle");
            for (int i = 0; i < NUM_REQ; i++)
                if (tbl[r].mask[i] && src_head[i] == src_tail[i]) push_src(i, 8'(16 * i + r), 1'b1);
            e = tbl[r].exp;
            exp_hdr(e);
            exp_byte(e, src_mem[e][src_head[e]][7:0]);
            a0 = acc_total;
            en_mask = tbl[r].mask;
            n = 0;
            while (acc_total == a0 && n < 200) begin @(negedge clk); #2; n++; end
            check("tbl_accept", 32'(n < 200), 1);
            en_mask = '0;
            wait_idle("tbl_idle");
            check("tbl_winner", last_acc_id, e);
            check("tbl_grant_id", 32'(grant_id), 32'(e));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
